frog_player_ctrl: RTL and testbench

Game-state stage directly upstream of the VGA renderer. It debounces the four Go Board buttons and steps the frog sprite on a grid once per frame. It tracks lives and level, and runs the death/respawn/win sequence. Its player_x/player_y outputs feed the renderer's player rectangle; the renderer returns a frame tick and a collision flag.

---
 rtl/frog_player_ctrl_pkg.sv | 37 +++
 rtl/frog_player_ctrl_button_debounce.sv | 49 ++++
 rtl/frog_player_ctrl.sv | 155 +++++++++++++++
 tb/tb_frog_player_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/frog_player_ctrl_pkg.sv
// Shared frog game geometry, FSM state encoding and pending-move encoding.
// The geometry constants are also used by the renderer and the car mover.
package frog_player_ctrl_pkg;

  localparam int H_DISPLAY     = 640;
  localparam int V_DISPLAY     = 480;
  localparam int PLAYER_WIDTH  = 32;
  localparam int PLAYER_HEIGHT = 32;
  localparam int STEP          = 32;
  localparam int START_X       = 304;
  localparam int START_Y       = 448;

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_DEAD,
    ST_WIN,
    ST_GAME_OVER
  } state_t;

  typedef enum logic [2:0] {
    MV_NONE,
    MV_UP,
    MV_DOWN,
    MV_LEFT,
    MV_RIGHT
  } move_t;

  // Bit 0 is up, bit 1 down, bit 2 left, bit 3 right; lower bits win on ties.
  function automatic move_t pick_move(input logic [3:0] presses);
    if (presses[0])      return MV_UP;
    else if (presses[1]) return MV_DOWN;
    else if (presses[2]) return MV_LEFT;
    else if (presses[3]) return MV_RIGHT;
    else                 return MV_NONE;
  endfunction

endpackage

// File: rtl/frog_player_ctrl_button_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push button.
// Produces the debounced level and a one-cycle pulse on its rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // The counter only advances while the synchronised input disagrees with
  // the debounced level, so any bounce back to agreement restarts it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/frog_player_ctrl.sv
// Frog player game state: debounced buttons, per-frame grid stepping,
// lives/level tracking and the death / win / game-over sequencing.
module frog_player_ctrl
  import frog_player_ctrl_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int MAX_LEVEL       = 9,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PAUSE_FRAMES    = 60
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       player_alive,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic       game_over
);

  localparam int PW = (PAUSE_FRAMES < 2) ? 1 : $clog2(PAUSE_FRAMES + 1);

  logic [3:0] raw_btn;
  logic [3:0] btn_level;
  logic [3:0] btn_press;

  assign raw_btn = {SW4, SW3, SW2, SW1};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .CLK  (CLK),
      .RST_N(RST_N),
      .raw  (raw_btn[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  state_t       state_q;
  move_t        pending_q;
  logic [9:0]   x_q, y_q;
  logic [1:0]   lives_q;
  logic [3:0]   level_q;
  logic [PW-1:0] pause_q;
  logic         alive_q;
  logic         game_over_q;

  move_t        press_move;
  logic         press_any;
  logic [10:0]  x_ext, y_ext;
  logic [9:0]   x_d, y_d;

  assign press_move = pick_move(btn_press);
  assign press_any  = |btn_press;

  // Clamped destination of the pending move; 11-bit math so nothing wraps.
  always_comb begin
    x_ext = {1'b0, x_q};
    y_ext = {1'b0, y_q};
    x_d   = x_q;
    y_d   = y_q;
    case (pending_q)
      MV_UP:    if (y_ext >= 11'(STEP)) y_d = 10'(y_ext - 11'(STEP));
      MV_DOWN:  if (y_ext + 11'(STEP) <= 11'(V_DISPLAY - PLAYER_HEIGHT)) y_d = 10'(y_ext + 11'(STEP));
      MV_LEFT:  if (x_ext >= 11'(STEP)) x_d = 10'(x_ext - 11'(STEP));
      MV_RIGHT: if (x_ext + 11'(STEP) <= 11'(H_DISPLAY - PLAYER_WIDTH)) x_d = 10'(x_ext + 11'(STEP));
      default:  ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_PLAY;
      pending_q   <= MV_NONE;
      x_q         <= 10'(START_X);
      y_q         <= 10'(START_Y);
      lives_q     <= 2'(LIVES);
      level_q     <= 4'd1;
      pause_q     <= '0;
      alive_q     <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (press_any) pending_q <= press_move;
          if (frame_tick) begin
            if (hit) begin
              pending_q <= MV_NONE;
              lives_q   <= lives_q - 1'b1;
              alive_q   <= 1'b0;
              pause_q   <= '0;
              if (lives_q == 2'd1) begin
                state_q     <= ST_GAME_OVER;
                game_over_q <= 1'b1;
              end else begin
                state_q <= ST_DEAD;
              end
            end else begin
              x_q <= x_d;
              y_q <= y_d;
              if (!press_any) pending_q <= MV_NONE;
              if (y_d == 10'd0) begin
                state_q   <= ST_WIN;
                pending_q <= MV_NONE;
                alive_q   <= 1'b0;
                pause_q   <= '0;
                if (level_q < 4'(MAX_LEVEL)) level_q <= level_q + 1'b1;
              end
            end
          end
        end
        ST_DEAD, ST_WIN: begin
          pending_q <= MV_NONE;
          if (frame_tick) begin
            if (pause_q == PW'(PAUSE_FRAMES - 1)) begin
              pause_q <= '0;
              x_q     <= 10'(START_X);
              y_q     <= 10'(START_Y);
              state_q <= ST_PLAY;
              alive_q <= 1'b1;
            end else begin
              pause_q <= pause_q + 1'b1;
            end
          end
        end
        default: begin
          pending_q <= MV_NONE;
          if (press_any) begin
            lives_q     <= 2'(LIVES);
            level_q     <= 4'd1;
            x_q         <= 10'(START_X);
            y_q         <= 10'(START_Y);
            state_q     <= ST_PLAY;
            alive_q     <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_alive = alive_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_frog_player_ctrl.sv
// Self-checking bench for frog_player_ctrl: directed scenarios followed by
// random button/tick sequences, checked against a rule-level game model.
module tb_frog_player_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       SW1, SW2, SW3, SW4;
  logic       frame_tick, hit;
  logic [9:0] player_x, player_y;
  logic       player_alive;
  logic [1:0] lives;
  logic [3:0] level;
  logic       game_over;

  int checks = 0;
  int failures = 0;

  // Model state: plain integers driven by the game rules.
  localparam int M_PLAY = 0, M_DEAD = 1, M_WIN = 2, M_OVER = 3;
  int mState, mX, mY, mLives, mLevel, mPending, mPause;

  frog_player_ctrl #(
    .LIVES(3), .MAX_LEVEL(9), .DEBOUNCE_CYCLES(4), .PAUSE_FRAMES(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
    .frame_tick(frame_tick), .hit(hit),
    .player_x(player_x), .player_y(player_y),
    .player_alive(player_alive), .lives(lives), .level(level),
    .game_over(game_over)
  );

  always #5 CLK = ~CLK;

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_x"}, 32'(player_x), 32'(mX));
    chk({tag, "_y"}, 32'(player_y), 32'(mY));
    chk({tag, "_lives"}, 32'(lives), 32'(mLives));
    chk({tag, "_level"}, 32'(level), 32'(mLevel));
    chk({tag, "_alive"}, 32'(player_alive), 32'(mState == M_PLAY));
    chk({tag, "_over"}, 32'(game_over), 32'(mState == M_OVER));
  endtask

  task automatic modelRestart();
    mState = M_PLAY; mX = 304; mY = 448; mLives = 3; mLevel = 1;
    mPending = 0; mPause = 0;
  endtask

  // Hold the buttons in mask long enough to debounce, release, then settle.
  task automatic applyStimulus(input logic [3:0] mask, input string tag);
    {SW4, SW3, SW2, SW1} = mask;
    waitCycles(12);
    {SW4, SW3, SW2, SW1} = 4'b0000;
    waitCycles(12);
    if (mask != 4'b0000) begin
      if (mState == M_PLAY) begin
        if (mask[0])      mPending = 1;
        else if (mask[1]) mPending = 2;
        else if (mask[2]) mPending = 3;
        else              mPending = 4;
      end else if (mState == M_OVER) begin
        modelRestart();
      end
    end
    checkOutput(tag);
  endtask

  // One frame tick with the given collision flag.
  task automatic frameTick(input logic h, input string tag);
    frame_tick = 1'b1;
    hit = h;
    waitCycles(1);
    frame_tick = 1'b0;
    hit = 1'b0;
    case (mState)
      M_PLAY: begin
        if (h) begin
          mLives = mLives - 1;
          mPending = 0;
          mPause = 0;
          mState = (mLives == 0) ? M_OVER : M_DEAD;
        end else begin
          case (mPending)
            1: if (mY >= 32) mY = mY - 32;
            2: if (mY + 32 <= 480 - 32) mY = mY + 32;
            3: if (mX >= 32) mX = mX - 32;
            4: if (mX + 32 <= 640 - 32) mX = mX + 32;
            default: ;
          endcase
          mPending = 0;
          if (mY == 0) begin
            mState = M_WIN;
            mPause = 0;
            if (mLevel < 9) mLevel = mLevel + 1;
          end
        end
      end
      M_DEAD, M_WIN: begin
        mPause = mPause + 1;
        if (mPause == 3) begin
          mPause = 0; mX = 304; mY = 448; mState = M_PLAY;
        end
      end
      default: ;
    endcase
    checkOutput(tag);
  endtask

  initial begin
    RST_N = 1'b0;
    {SW4, SW3, SW2, SW1} = 4'b0000;
    frame_tick = 1'b0;
    hit = 1'b0;
    modelRestart();
    waitCycles(3);
    RST_N = 1'b1;
    checkOutput("reset");

    // Scenario 1: single UP press then a tick.
    applyStimulus(4'b0001, "up_press");
    frameTick(1'b0, "up_tick");

    // Scenario 2: bouncing left button never registers.
    for (int i = 0; i < 5; i++) begin
      SW3 = 1'b1; waitCycles(2);
      SW3 = 1'b0; waitCycles(2);
    end
    waitCycles(12);
    checkOutput("bounce_idle");
    for (int i = 0; i < 3; i++) frameTick(1'b0, "bounce_tick");

    // Scenario 3: walk left into the wall, then confirm the blocked move was consumed.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(4'b0100, "left_press");
      frameTick(1'b0, "left_tick");
    end
    frameTick(1'b0, "left_consumed");

    // Scenario 4: climb to y=32, then get hit with UP pending.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'b0001, "climb_press");
      frameTick(1'b0, "climb_tick");
    end
    applyStimulus(4'b0001, "hit_press");
    frameTick(1'b1, "hit_tick");
    applyStimulus(4'b0010, "dead_press");
    for (int i = 0; i < 3; i++) frameTick(1'b0, "dead_tick");

    // Scenario 5: reach the top row and win.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(4'b0001, "win_press");
      frameTick(1'b0, "win_tick");
    end
    for (int i = 0; i < 3; i++) frameTick(1'b0, "win_pause");

    // Scenario 6: lose remaining lives, then restart with a press.
    frameTick(1'b1, "death2");
    for (int i = 0; i < 3; i++) frameTick(1'b0, "death2_pause");
    frameTick(1'b1, "death3");
    frameTick(1'b1, "over_hold");
    applyStimulus(4'b1000, "restart");

    // Simultaneous presses exercise the priority order.
    applyStimulus(4'b1100, "prio_lr");
    frameTick(1'b0, "prio_lr_tick");
    applyStimulus(4'b0110, "prio_dl");
    frameTick(1'b0, "prio_dl_tick");

    // Random play against the model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] mask;
      int nTicks;
      mask = 4'($urandom_range(0, 15));
      applyStimulus(mask, "rand_press");
      nTicks = $urandom_range(1, 2);
      for (int t = 0; t < nTicks; t++)
        frameTick(($urandom_range(0, 7) == 0), "rand_tick");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
